// File: rtl/fir_lut_loader.sv
// Distributed-arithmetic LUT loader: collects LUT_SIZE signed coefficients per LUT,
// then writes all 2^LUT_SIZE signed +/- partial sums, for NUM_LUTS LUTs per session.
module fir_lut_loader #(
    parameter int LUT_SIZE = 4,
    parameter int NUM_LUTS = 8,
    parameter int COEF_W   = 16,
    localparam int DATA_W  = COEF_W + $clog2(LUT_SIZE) + 1,
    localparam int LUT_W   = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     coef_valid,
    output logic                     coef_ready,
    output logic                     wr_en,
    output logic [LUT_W-1:0]         wr_lut,
    output logic [LUT_SIZE-1:0]      wr_addr,
    output logic signed [DATA_W-1:0] wr_data,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_W = (LUT_SIZE > 1) ? $clog2(LUT_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_COEF = CNT_W'(LUT_SIZE - 1);
    localparam logic [LUT_W-1:0] LAST_LUT  = LUT_W'(NUM_LUTS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_BUILD   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]                state;
    logic [CNT_W-1:0]          coef_cnt;
    logic [LUT_W-1:0]          lut_cnt;
    logic [LUT_SIZE-1:0]       addr_cnt;
    logic signed [COEF_W-1:0]  slots [LUT_SIZE];
    logic signed [DATA_W-1:0]  entry_sum;
    logic signed [DATA_W-1:0]  term;

    // Terms are widened before negation so that -(-2^(COEF_W-1)) stays exact.
    always_comb begin
        entry_sum = '0;
        term      = '0;
        for (int i = 0; i < LUT_SIZE; i++) begin
            term = {{(DATA_W-COEF_W){slots[i][COEF_W-1]}}, slots[i]};
            if (addr_cnt[i])
                entry_sum = entry_sum + term;
            else
                entry_sum = entry_sum - term;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            coef_cnt <= '0;
            lut_cnt  <= '0;
            addr_cnt <= '0;
            wr_en    <= 1'b0;
            wr_lut   <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            for (int i = 0; i < LUT_SIZE; i++)
                slots[i] <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_COLLECT;
                        lut_cnt  <= '0;
                        coef_cnt <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (coef_valid) begin
                        slots[coef_cnt] <= coef_data;
                        if (coef_cnt == LAST_COEF) begin
                            state    <= ST_BUILD;
                            coef_cnt <= '0;
                            addr_cnt <= '0;
                        end else begin
                            coef_cnt <= coef_cnt + 1'b1;
                        end
                    end
                end
                ST_BUILD: begin
                    wr_en    <= 1'b1;
                    wr_lut   <= lut_cnt;
                    wr_addr  <= addr_cnt;
                    wr_data  <= entry_sum;
                    addr_cnt <= addr_cnt + 1'b1;
                    // The address counter wraps to 0 by width on the last entry.
                    if (addr_cnt == '1) begin
                        if (lut_cnt < LAST_LUT) begin
                            lut_cnt  <= lut_cnt + 1'b1;
                            coef_cnt <= '0;
                            state    <= ST_COLLECT;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign coef_ready = (state == ST_COLLECT);
    assign busy       = (state == ST_COLLECT) || (state == ST_BUILD);
    assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_fir_lut_loader.sv
// Directed bench: a 2-tap/1-LUT instance with hand-computed entries, and a default
// instance checked against a small model of the +/- coefficient sums.
module tb_fir_lut_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Small instance: LUT_SIZE=2, NUM_LUTS=1, COEF_W=16 -> DATA_W=18
    logic               start_a = 1'b0;
    logic signed [15:0] coef_data_a = '0;
    logic               coef_valid_a = 1'b0;
    logic               coef_ready_a, wr_en_a, busy_a, done_a;
    logic [0:0]         wr_lut_a;
    logic [1:0]         wr_addr_a;
    logic signed [17:0] wr_data_a;

    // Default instance: LUT_SIZE=4, NUM_LUTS=8, COEF_W=16 -> DATA_W=19
    logic               start_b = 1'b0;
    logic signed [15:0] coef_data_b = '0;
    logic               coef_valid_b = 1'b0;
    logic               coef_ready_b, wr_en_b, busy_b, done_b;
    logic [2:0]         wr_lut_b;
    logic [3:0]         wr_addr_b;
    logic signed [18:0] wr_data_b;

    fir_lut_loader #(.LUT_SIZE(2), .NUM_LUTS(1), .COEF_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .coef_data(coef_data_a),
        .coef_valid(coef_valid_a), .coef_ready(coef_ready_a), .wr_en(wr_en_a),
        .wr_lut(wr_lut_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .busy(busy_a), .done(done_a)
    );

    fir_lut_loader dut_b (
        .clk(clk), .rst(rst), .start(start_b), .coef_data(coef_data_b),
        .coef_valid(coef_valid_b), .coef_ready(coef_ready_b), .wr_en(wr_en_b),
        .wr_lut(wr_lut_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .done(done_b)
    );

    typedef struct { int lut; int addr; int data; } wr_t;
    wr_t q_a[$];
    wr_t q_b[$];
    int coef_tab[8][4];

    always @(negedge clk) begin
        if (wr_en_a) q_a.push_back('{int'(wr_lut_a), int'(wr_addr_a), int'(wr_data_a)});
        if (wr_en_b) q_b.push_back('{int'(wr_lut_b), int'(wr_addr_b), int'(wr_data_b)});
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int modelEntry(input int lut, input int addr);
        int s = 0;
        for (int k = 0; k < 4; k++)
            s += ((addr >> k) & 1) ? coef_tab[lut][k] : -coef_tab[lut][k];
        return s;
    endfunction

    task automatic pulseStartB();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
    endtask

    // Garbage with valid high is presented while not ready; it must never be captured.
    task automatic applyStimulus(input int lut, input bit toggle);
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            coef_valid_b = 1'b1;
            coef_data_b  = 16'sh7777;
            while (!coef_ready_b && n < 300) begin
                tick();
                n++;
            end
            if (n >= 300) checkOutput("ready_timeout", n, 0);
            coef_data_b = 16'(coef_tab[lut][k]);
            tick();
            if (toggle) begin
                coef_valid_b = 1'b0;
                coef_data_b  = 16'sh5555;
                tick();
            end
        end
        coef_valid_b = 1'b1;
        coef_data_b  = 16'sh7777;
    endtask

    task automatic waitDoneB();
        int n = 0;
        while (!done_b && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) checkOutput("done_timeout", n, 0);
        tick();
    endtask

    task automatic verifySession();
        int lim;
        checkOutput("write_count", q_b.size(), 128);
        lim = (q_b.size() < 128) ? q_b.size() : 128;
        for (int i = 0; i < lim; i++) begin
            checkOutput("wr_pos", q_b[i].lut * 16 + q_b[i].addr, i);
            checkOutput("wr_data", q_b[i].data, modelEntry(i / 16, i % 16));
        end
    endtask

    initial begin
        int expd[4];
        expd = '{2, 8, -8, -2};

        rst = 1'b0;
        tick(); tick();
        checkOutput("rst_coef_ready", int'(coef_ready_b), 0);
        checkOutput("rst_wr_en", int'(wr_en_b), 0);
        checkOutput("rst_wr_lut", int'(wr_lut_b), 0);
        checkOutput("rst_wr_addr", int'(wr_addr_b), 0);
        checkOutput("rst_wr_data", int'(wr_data_b), 0);
        checkOutput("rst_busy", int'(busy_b), 0);
        checkOutput("rst_done", int'(done_b), 0);
        rst = 1'b1;
        tick();

        $display("[TB] small instance: coefs 3, -5");
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        checkOutput("a_busy", int'(busy_a), 1);
        coef_valid_a = 1'b1;
        coef_data_a  = 16'sd3;
        tick();
        coef_data_a  = -16'sd5;
        tick();
        coef_valid_a = 1'b0;
        for (int n = 0; n < 20 && !done_a; n++) tick();
        tick();
        checkOutput("a_done", int'(done_a), 1);
        checkOutput("a_busy_end", int'(busy_a), 0);
        checkOutput("a_count", q_a.size(), 4);
        for (int i = 0; i < 4 && i < q_a.size(); i++) begin
            checkOutput("a_addr", q_a[i].addr, i);
            checkOutput("a_data", q_a[i].data, expd[i]);
        end

        $display("[TB] default instance: valid in IDLE, toggled valid, start in BUILD");
        coef_valid_b = 1'b1;
        coef_data_b  = 16'sh7777;
        tick(); tick();
        checkOutput("idle_ready", int'(coef_ready_b), 0);
        for (int l = 0; l < 8; l++)
            for (int k = 0; k < 4; k++)
                coef_tab[l][k] = (l * 37 + k * 1000 + 11) * ((k % 2) ? -1 : 1);
        q_b.delete();
        pulseStartB();
        for (int l = 0; l < 8; l++) begin
            applyStimulus(l, 1'b1);
            if (l == 2) begin
                tick();
                checkOutput("build_ready", int'(coef_ready_b), 0);
                pulseStartB();
                checkOutput("build_busy", int'(busy_b), 1);
            end
        end
        waitDoneB();
        checkOutput("done_flag", int'(done_b), 1);
        checkOutput("done_busy", int'(busy_b), 0);
        verifySession();

        $display("[TB] default instance: most-negative and most-positive coefficients");
        for (int l = 0; l < 8; l++)
            for (int k = 0; k < 4; k++)
                coef_tab[l][k] = (l == 0) ? -32768 : (l == 1) ? 32767 : (k - 2) * 900 + l;
        q_b.delete();
        pulseStartB();
        checkOutput("restart_done", int'(done_b), 0);
        for (int l = 0; l < 8; l++) applyStimulus(l, 1'b0);
        waitDoneB();
        verifySession();
        if (q_b.size() >= 16) begin
            checkOutput("neg_addr0", q_b[0].data, 131072);
            checkOutput("neg_addr15", q_b[15].data, -131072);
        end else begin
            checkOutput("neg_count", q_b.size(), 16);
        end

        $display("[TB] default instance: reset during BUILD of LUT 3");
        q_b.delete();
        pulseStartB();
        for (int l = 0; l < 4; l++) applyStimulus(l, 1'b0);
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        checkOutput("mid_wr_en", int'(wr_en_b), 0);
        checkOutput("mid_wr_lut", int'(wr_lut_b), 0);
        checkOutput("mid_wr_addr", int'(wr_addr_b), 0);
        checkOutput("mid_wr_data", int'(wr_data_b), 0);
        checkOutput("mid_busy", int'(busy_b), 0);
        checkOutput("mid_ready", int'(coef_ready_b), 0);
        q_b.delete();
        rst = 1'b1;
        for (int n = 0; n < 40; n++) tick();
        checkOutput("no_writes_after_rst", q_b.size(), 0);
        checkOutput("idle_after_rst", int'(busy_b), 0);

        q_b.delete();
        pulseStartB();
        for (int l = 0; l < 8; l++) applyStimulus(l, 1'b0);
        waitDoneB();
        verifySession();

        coef_valid_b = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
